// File: rtl/sccb_slave_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sccb_slave_if : SCCB pins and register-bus signals of sccb_slave  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface sccb_slave_if;
  logic        scl;
  logic        sda_i;
  logic        sda_o;
  logic        sda_oe;
  logic        reg_wr;
  logic        reg_rd;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wdata;
  logic [7:0]  reg_rdata;
  logic        busy;

  modport slave (
    input  scl, sda_i, reg_rdata,
    output sda_o, sda_oe, reg_wr, reg_rd, reg_addr, reg_wdata, busy
  );

  modport master (
    output scl, sda_i, reg_rdata,
    input  sda_o, sda_oe, reg_wr, reg_rd, reg_addr, reg_wdata, busy
  );
endinterface
`default_nettype wire

// File: rtl/sccb_slave.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sccb_slave : SCCB/I2C responder, 16-bit register pointer, 8-bit   |
// | data, single-cycle register-bus strobes.           Rev 1.0        |
// +------------------------------------------------------------------+
module sccb_slave #(
  parameter logic [6:0] DEV_ADDR = 7'h3C
) (
  input wire          clk,
  input wire          rst_n,
  sccb_slave_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_DEVA, S_DACK, S_AH, S_AHACK, S_AL, S_ALACK,
    S_WDAT, S_WACK, S_RDAT, S_MACK, S_IGNORE
  } state_t;

  state_t      r_state;
  logic        r_scl_s1, r_scl_s2, r_scl_d;
  logic        r_sda_s1, r_sda_s2, r_sda_d;
  logic [3:0]  r_bit_cnt;
  logic [7:0]  r_rx;
  logic [7:0]  r_tx;
  logic [7:0]  r_addr_hi;
  logic [7:0]  r_wdata;
  logic [15:0] r_ptr;
  logic        r_rw;
  logic        r_rd_req;
  logic        r_reg_wr;
  logic        r_reg_rd;
  logic        r_sda_oe;
  logic        r_busy;

  logic        w_scl_rise, w_scl_fall, w_start, w_stop, w_last_bit;
  logic [7:0]  w_byte;

  assign w_scl_rise = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s2 & r_scl_d;
  assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
  assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
  assign w_byte     = {r_rx[6:0], r_sda_s2};
  assign w_last_bit = (r_bit_cnt == 4'd7);

  assign bus.sda_o     = 1'b0;
  assign bus.sda_oe    = r_sda_oe;
  assign bus.reg_wr    = r_reg_wr;
  assign bus.reg_rd    = r_reg_rd;
  assign bus.reg_addr  = r_ptr;
  assign bus.reg_wdata = r_wdata;
  assign bus.busy      = r_busy;

  // Synchronizers idle high so leaving reset never looks like a START.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_scl_d  <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
      r_sda_d  <= 1'b1;
    end else begin
      r_scl_s1 <= bus.scl;
      r_scl_s2 <= r_scl_s1;
      r_scl_d  <= r_scl_s2;
      r_sda_s1 <= bus.sda_i;
      r_sda_s2 <= r_sda_s1;
      r_sda_d  <= r_sda_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= 4'd0;
      r_rx      <= 8'd0;
      r_tx      <= 8'd0;
      r_addr_hi <= 8'd0;
      r_wdata   <= 8'd0;
      r_ptr     <= 16'd0;
      r_rw      <= 1'b0;
      r_rd_req  <= 1'b0;
      r_reg_wr  <= 1'b0;
      r_reg_rd  <= 1'b0;
      r_sda_oe  <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_reg_wr <= 1'b0;
      r_reg_rd <= r_rd_req;
      r_rd_req <= 1'b0;
      if (r_reg_wr) r_ptr <= r_ptr + 16'd1;
      if (r_reg_rd) r_tx <= bus.reg_rdata;

      if (w_start) begin
        r_state   <= S_DEVA;
        r_bit_cnt <= 4'd0;
        r_sda_oe  <= 1'b0;
      end else if (w_stop) begin
        r_state  <= S_IDLE;
        r_sda_oe <= 1'b0;
        r_busy   <= 1'b0;
      end else begin
        case (r_state)
          S_DEVA, S_AH, S_AL, S_WDAT: begin
            if (w_scl_rise) begin
              r_rx      <= w_byte;
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (w_last_bit) begin
                r_bit_cnt <= 4'd0;
                case (r_state)
                  S_DEVA: begin
                    if (w_byte[7:1] == DEV_ADDR) begin
                      r_busy   <= 1'b1;
                      r_rw     <= w_byte[0];
                      r_reg_rd <= w_byte[0];
                      r_state  <= S_DACK;
                    end else begin
                      r_busy  <= 1'b0;
                      r_state <= S_IGNORE;
                    end
                  end
                  S_AH: begin
                    r_addr_hi <= w_byte;
                    r_state   <= S_AHACK;
                  end
                  S_AL: begin
                    r_ptr   <= {r_addr_hi, w_byte};
                    r_state <= S_ALACK;
                  end
                  default: begin
                    r_reg_wr <= 1'b1;
                    r_wdata  <= w_byte;
                    r_state  <= S_WACK;
                  end
                endcase
              end
            end
          end
          // First fall pulls SDA low for the ACK, second fall ends the slot.
          S_DACK, S_AHACK, S_ALACK, S_WACK: begin
            if (w_scl_fall) begin
              if (!r_sda_oe) begin
                r_sda_oe <= 1'b1;
              end else begin
                r_sda_oe  <= 1'b0;
                r_bit_cnt <= 4'd0;
                case (r_state)
                  S_DACK: begin
                    if (r_rw) begin
                      r_state  <= S_RDAT;
                      r_sda_oe <= ~r_tx[7];
                      r_tx     <= {r_tx[6:0], 1'b1};
                    end else begin
                      r_state <= S_AH;
                    end
                  end
                  S_AHACK: r_state <= S_AL;
                  default: r_state <= S_WDAT;
                endcase
              end
            end
          end
          S_RDAT: begin
            if (w_scl_rise) begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall) begin
              if (r_bit_cnt == 4'd8) begin
                r_sda_oe <= 1'b0;
                r_state  <= S_MACK;
              end else begin
                r_sda_oe <= ~r_tx[7];
                r_tx     <= {r_tx[6:0], 1'b1};
              end
            end
          end
          // A fall in MACK can only follow an ACKed rise; NACK leaves first.
          S_MACK: begin
            if (w_scl_rise) begin
              if (r_sda_s2) begin
                r_busy  <= 1'b0;
                r_state <= S_IGNORE;
              end else begin
                r_ptr    <= r_ptr + 16'd1;
                r_rd_req <= 1'b1;
              end
            end else if (w_scl_fall) begin
              r_state   <= S_RDAT;
              r_bit_cnt <= 4'd0;
              r_sda_oe  <= ~r_tx[7];
              r_tx      <= {r_tx[6:0], 1'b1};
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
